bin2bcd_seq: RTL

Sequential 32-bit binary to 8-digit packed-BCD converter, placed directly upstream of the eight-digit seven-segment display driver. It turns a binary value into decimal digits with the shift-and-add-3 (double-dabble) method, one bit per clock. Its `dig[31:0]` output feeds the display driver's digit input. The output is registered and holds its last value during a conversion, so the display never shows intermediate data.

---
 rtl/display_pkg.sv | 23 ++
 rtl/bcd_add3.sv | 9 +
 rtl/bin2bcd_seq.sv | 103 ++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// display_pkg: shared constants and state encoding for the display datapath
package display_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam int W_BIN_DEF  = 32;
    localparam int DIGITS_DEF = 8;

    localparam logic [31:0] BCD_MAX = 32'h9999_9999;
    localparam logic [31:0] DEC_MAX = 32'd99_999_999;

    // Largest value representable in the given number of decimal digits
    function automatic logic [63:0] dec_limit(input int digits);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < digits; i++) p = p * 64'd10;
        return p - 64'd1;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// bcd_add3: double-dabble digit adjust, adds 3 to any digit of 5 or more
module bcd_add3 (
    input  logic [3:0] in_i,
    output logic [3:0] out_o
);

    assign out_o = (in_i >= 4'd5) ? in_i + 4'd3 : in_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary to packed-BCD converter, one bit per clock
module bin2bcd_seq
    import display_pkg::*;
#(
    parameter int W_BIN  = W_BIN_DEF,
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [W_BIN-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   dig,
    output logic                  ovf
);

    localparam int CW = $clog2(W_BIN) + 1;
    localparam int AW = 4 * DIGITS;

    state_e            state_q, state_d;
    logic [W_BIN-1:0]  sr_q, sr_d;
    logic [AW-1:0]     acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              flag_q, flag_d;
    logic              done_q, done_d;
    logic [AW-1:0]     dig_q, dig_d;
    logic              ovf_q, ovf_d;
    logic [AW-1:0]     adj;
    logic [AW+W_BIN-1:0] shifted;

    genvar d;
    generate
        for (d = 0; d < DIGITS; d++) begin : g_adj
            bcd_add3 u_add3 (
                .in_i  (acc_q[4*d +: 4]),
                .out_o (adj[4*d +: 4])
            );
        end
    endgenerate

    assign shifted = {adj, sr_q} << 1;

    // Next-state: load on accepted start, one adjust-and-shift step per cycle in SHIFT
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        flag_d  = flag_q;
        done_d  = 1'b0;
        dig_d   = dig_q;
        ovf_d   = ovf_q;
        if (state_q == IDLE) begin
            if (start) begin
                state_d = SHIFT;
                sr_d    = bin;
                acc_d   = '0;
                cnt_d   = '0;
                flag_d  = 64'(bin) > dec_limit(DIGITS);
            end
        end else begin
            sr_d  = shifted[W_BIN-1:0];
            acc_d = shifted[AW+W_BIN-1:W_BIN];
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(W_BIN - 1)) begin
                state_d = IDLE;
                done_d  = 1'b1;
                dig_d   = flag_q ? {DIGITS{4'h9}} : shifted[AW+W_BIN-1:W_BIN];
                ovf_d   = flag_q;
            end
        end
    end

    // State and output registers; reset aborts any conversion in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            flag_q  <= 1'b0;
            done_q  <= 1'b0;
            dig_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            flag_q  <= flag_d;
            done_q  <= done_d;
            dig_q   <= dig_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == SHIFT);
    assign done = done_q;
    assign dig  = dig_q;
    assign ovf  = ovf_q;

endmodule
